// File: rtl/fir_inverse.sv
// Inverse of a fixed-coefficient FIR (C = 1..N, leading unity tap): recovers x[n] from y[n]
// by subtracting one weighted history tap per cycle, then saturating into the output register.
module fir_inverse #(
  parameter int N  = 5,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat
);

  // Tap k uses coefficient k+1, so the largest coefficient is N.
  localparam int AW = DW + 2 + $clog2(N * N);
  localparam int KW = $clog2(N) + 1;

  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q;
  logic        [KW-1:0]  k_q;
  logic signed [DW-1:0]  hist_q [N-1];

  logic signed [DW-1:0]  hist_sel;
  logic signed [AW-1:0]  hist_ext;
  logic signed [AW-1:0]  coef;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  acc_next;
  logic signed [DW-1:0]  sat_val;
  logic                  sat_flag;
  logic                  last_tap;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign last_tap  = (k_q == KW'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (last_tap) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    hist_sel = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (k_q == KW'(i + 1)) hist_sel = hist_q[i];
    end
    hist_ext = {{(AW-DW){hist_sel[DW-1]}}, hist_sel};
    coef     = $signed(AW'(k_q) + AW'(1));
    term     = coef * hist_ext;
    acc_next = acc_q - term;
    sat_flag = 1'b0;
    sat_val  = acc_next[DW-1:0];
    if (acc_next > SAT_HI) begin
      sat_flag = 1'b1;
      sat_val  = SAT_HI[DW-1:0];
    end else if (acc_next < SAT_LO) begin
      sat_flag = 1'b1;
      sat_val  = SAT_LO[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      k_q      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      for (int i = 0; i < N - 1; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        for (int i = 0; i < N - 1; i++) hist_q[i] <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              acc_q <= {{(AW-DW){in_data[DW-1]}}, in_data};
              k_q   <= KW'(1);
            end
          end
          MAC: begin
            acc_q <= acc_next;
            k_q   <= k_q + KW'(1);
            if (last_tap) begin
              out_data <= sat_val;
              out_sat  <= sat_flag;
            end
          end
          HOLD: begin
            // History holds the saturated outputs actually delivered.
            if (out_ready) begin
              for (int i = N - 2; i > 0; i--) hist_q[i] <= hist_q[i-1];
              hist_q[0] <= out_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_inverse.sv
// Bench for fir_inverse: directed vectors plus random samples against an arithmetic
// recursion model x = y - sum (k+1)*x[n-k], clipped to the signed DW-bit range.
module tb_fir_inverse;

  localparam int N  = 5;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst, clear, in_valid, out_ready;
  logic                 in_ready, out_valid, out_sat;
  logic signed [DW-1:0] in_data, out_data;

  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  int     last_hs;
  longint mh [N-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_inverse #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_raw(input longint y);
    longint a;
    a = y;
    for (int k = 1; k < N; k++) a = a - longint'(k + 1) * mh[k-1];
    return a;
  endfunction

  function automatic longint clip(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N - 1; i++) mh[i] = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
  task automatic run_sample(input logic signed [63:0] y, input int stall, input bit clr_out,
                            output logic signed [63:0] got);
    longint raw, expx;
    int     lat, wt;
    raw = model_raw(longint'(y));
    expx = clip(raw);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = DW'(y);
    wt = 0;
    while (!in_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("in_ready_wait", in_ready, 1);
    last_hs = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    chk("mac_in_ready", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, N);
    got = out_data;
    chk("out_data", out_data, expx);
    chk("out_sat", out_sat, (raw != expx) ? 1 : 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, expx);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    clear     = clr_out;
    @(negedge clk);
    clear = 1'b0;
    if (clr_out) model_clear();
    else begin
      for (int i = N - 2; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = expx;
    end
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic count_outputs(input int ncyc, output int seen);
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
  endtask

  initial begin
    logic signed [63:0] got;
    logic signed [DW-1:0] r;
    int hs_a, seen;
    int rt_y [5]  = '{1, 4, 10, 20, 35};
    int imp_x [5] = '{1, -2, 1, 0, 0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(negedge clk);

    // Round trip of the forward FIR of 1..5, plus throughput between back-to-back samples
    for (int i = 0; i < 5; i++) begin
      run_sample(rt_y[i], 0, 1'b0, got);
      chk("roundtrip", got, i + 1);
      if (i == 1) hs_a = last_hs;
      if (i == 2) chk("throughput", last_hs - hs_a, N + 1);
    end

    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? 1 : 0, 0, 1'b0, got);
      chk("impulse", got, imp_x[i]);
    end

    pulse_reset();
    run_sample(-32768, 0, 1'b0, got);
    chk("sat_lo", got, -32768);
    chk("sat_lo_flag", out_sat, 0);
    run_sample(32767, 0, 1'b0, got);
    chk("sat_hi", got, 32767);
    chk("sat_hi_flag", out_sat, 1);
    run_sample(0, 0, 1'b0, got);

    run_sample(7, 10, 1'b0, got);

    // Reset during the second MAC cycle of the third sample
    pulse_reset();
    run_sample(1, 0, 1'b0, got);
    run_sample(4, 0, 1'b0, got);
    in_valid = 1'b1; in_data = 16'sd10;
    seen = 0;
    while (!in_ready && seen < 50) begin @(negedge clk); seen++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("abort_in_ready", in_ready, 1);
    count_outputs(8, seen);
    chk("abort_no_out", seen, 0);
    run_sample(1, 0, 1'b0, got);
    chk("after_abort", got, 1);

    // Clear after history builds up, clear against input handshake, clear against output handshake
    pulse_reset();
    run_sample(1, 0, 1'b0, got);
    run_sample(4, 0, 1'b0, got);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    run_sample(1, 0, 1'b0, got);
    chk("clear_hist", got, 1);
    in_valid = 1'b1; in_data = 16'sd77; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    model_clear();
    chk("clear_drop_ready", in_ready, 1);
    count_outputs(8, seen);
    chk("clear_drop_no_out", seen, 0);
    run_sample(3, 0, 1'b0, got);
    chk("clear_drop_next", got, 3);
    run_sample(5, 0, 1'b1, got);
    run_sample(2, 0, 1'b0, got);
    chk("clear_out_hs", got, 2);

    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      r = DW'($urandom);
      run_sample(r, int'($urandom_range(0, 3)), 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
